// File: rtl/vlsu_param.sv
// Vector load/store unit: maps element addresses onto a LANES-wide RAM word.
// It handles scalar, unit-stride and strided accesses. Define VLSU_STRIDE_EN to enable strided access.
module vlsu_lane #(
  parameter int LANE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                beEn,
  input  logic                capEn,
  input  logic [LANE_W-1:0]   capData,
  output logic [LANE_W/8-1:0] byteEn,
  output logic [LANE_W-1:0]   rdata
);
  assign byteEn = {(LANE_W/8){beEn}};

  always_ff @(posedge clk) begin
    if (reset)      rdata <= '0;
    else if (capEn) rdata <= capData;
  end
endmodule

module vlsu_param #(
  parameter int LANES   = 16,
  parameter int LANE_W  = 16,
  parameter int ADDR_W  = 14,
  parameter int RAM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic                      vec_mode,
  input  logic [31:0]               addr,
  input  logic [ADDR_W-1:0]         stride,
  input  logic [LANE_W-1:0]         scalar_wdata,
  input  logic [LANES*LANE_W-1:0]   vec_wdata,
  output logic                      busy,
  output logic [31:0]               scalar_rdata,
  output logic [LANES*LANE_W-1:0]   vec_rdata,
  input  logic [LANES*LANE_W-1:0]   ram_rdata,
  output logic                      ram_rden,
  output logic                      ram_wren,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [LANES*LANE_W/8-1:0] ram_byteena,
  output logic [LANES*LANE_W-1:0]   ram_wdata
);
  localparam int LG = $clog2(LANES);
  localparam int EW = ADDR_W + LG;
  localparam int BW = LANES * LANE_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, nextState;

  logic isWr, isVec, isStr;
  logic [EW-1:0] curAddr, strideR;
  logic [BW-1:0] wbuf;
  logic [LG-1:0] beatCnt;
  logic [RAM_LAT:1] vldReg;
  logic [RAM_LAT:0] vldPipe;
  logic [31:0] scalarR;
  logic [LANE_W-1:0] selLane;
  logic [LANES-1:0] beEn, capEn;
  logic [LANES-1:0][LANE_W-1:0] capData;
  logic req, strReq, accept, capture, beatDone, lastBeat;
  logic [LG-1:0] curLane;

  assign req      = mem_read | mem_write;
  assign accept   = (state == IDLE) && req;
  assign curLane  = curAddr[LG-1:0];
  assign vldPipe  = {vldReg, ram_rden};
  assign capture  = (state == WAIT) && vldPipe[RAM_LAT];
  assign beatDone = ((state == ISSUE) && isWr) || capture;
  assign lastBeat = !isStr || (beatCnt == LG'(LANES-1));
  assign selLane  = ram_rdata[curLane*LANE_W +: LANE_W];

`ifdef VLSU_STRIDE_EN
  assign strReq = vec_mode && (stride != ADDR_W'(1));
`else
  assign strReq = 1'b0;
`endif

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    case (state)
      IDLE: begin
        busy = req;
        if (req) nextState = ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        ram_wren = isWr;
        ram_rden = !isWr;
        if (isWr) nextState = lastBeat ? DONE : ISSUE;
        else      nextState = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (capture) nextState = lastBeat ? DONE : ISSUE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign ram_addr     = curAddr[EW-1:LG];
  assign scalar_rdata = scalarR;
  // Strided beats carry one element, replicated so the byte enables pick the lane.
  assign ram_wdata = ((state == ISSUE) && isWr)
                   ? (isStr ? {LANES{wbuf[beatCnt*LANE_W +: LANE_W]}} : wbuf) : '0;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      beEn[i]    = (state == ISSUE) && ((isVec && !isStr) || (curLane == LG'(i)));
      capEn[i]   = capture && isVec && (!isStr || (beatCnt == LG'(i)));
      capData[i] = isStr ? selLane : ram_rdata[i*LANE_W +: LANE_W];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : gLane
    vlsu_lane #(.LANE_W(LANE_W)) uLane (
      .clk     (clk),
      .reset   (reset),
      .beEn    (beEn[i]),
      .capEn   (capEn[i]),
      .capData (capData[i]),
      .byteEn  (ram_byteena[i*LANE_W/8 +: LANE_W/8]),
      .rdata   (vec_rdata[i*LANE_W +: LANE_W])
    );
  end

  // Clearing vldReg on reset drops any read still in flight in the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      isWr    <= 1'b0;
      isVec   <= 1'b0;
      isStr   <= 1'b0;
      curAddr <= '0;
      strideR <= '0;
      wbuf    <= '0;
      beatCnt <= '0;
      vldReg  <= '0;
      scalarR <= '0;
    end else begin
      state  <= nextState;
      vldReg <= vldPipe[RAM_LAT-1:0];
      if (accept) begin
        isWr    <= mem_write;
        isVec   <= vec_mode;
        isStr   <= strReq;
        curAddr <= addr[EW-1:0];
        strideR <= EW'(stride);
        wbuf    <= vec_mode ? vec_wdata : {LANES{scalar_wdata}};
        beatCnt <= '0;
      end else if (beatDone) begin
        beatCnt <= beatCnt + 1'b1;
        curAddr <= curAddr + strideR;
      end
      if (capture && !isVec) scalarR <= 32'(selLane);
    end
  end
endmodule

// File: tb/tb_vlsu_param.sv
// Scoreboard bench for vlsu_param: a reference model predicts each access and a monitor checks it at DONE.
module tb_vlsu_param;
  localparam int LANES = 16, LANE_W = 16, ADDR_W = 14, RAM_LAT = 1;
  localparam int BW = LANES * LANE_W, BE = BW / 8, EW = ADDR_W + 4, NW = 1 << ADDR_W;
`ifdef VLSU_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic mem_read = 0, mem_write = 0, vec_mode = 0;
  logic [31:0] addr = '0;
  logic [ADDR_W-1:0] stride = '0;
  logic [LANE_W-1:0] scalar_wdata = '0;
  logic [BW-1:0] vec_wdata = '0;
  logic busy, ram_rden, ram_wren;
  logic [31:0] scalar_rdata;
  logic [BW-1:0] vec_rdata, ram_rdata, ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [BE-1:0] ram_byteena;

  vlsu_param #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .vec_mode(vec_mode),
    .addr(addr), .stride(stride), .scalar_wdata(scalar_wdata), .vec_wdata(vec_wdata),
    .busy(busy), .scalar_rdata(scalar_rdata), .vec_rdata(vec_rdata), .ram_rdata(ram_rdata),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_byteena(ram_byteena),
    .ram_wdata(ram_wdata));

  always #5 clk = ~clk;

  typedef struct {
    bit wr; int beats; int lat; int bePB; int firstWord;
    logic [31:0] expS; logic [BW-1:0] expV;
    int nWords; logic [LANES-1:0][ADDR_W-1:0] words;
  } item_t;

  item_t sbq[$];
  int checks = 0, errors = 0;
  int doneCnt = 0, strobeCnt = 0, strayCnt = 0, bothCnt = 0;
  logic [BW-1:0] mem [NW];
  logic [BW-1:0] refMem [NW];
  logic [BW-1:0] rdPipe [RAM_LAT];
  logic [31:0] curS;
  logic [BW-1:0] curV;
  bit memReady = 1'b0;

  function automatic logic [BW-1:0] memInit(int w);
    logic [BW-1:0] v;
    for (int k = 0; k < BW/32; k++) v[k*32 +: 32] = 32'((w*8+k) * 32'h9E3779B1 + 32'h7F4A7C15);
    return v;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM with RAM_LAT-cycle registered read and byte-enabled write
  always @(posedge clk) begin
    if (!memReady) begin
      for (int w = 0; w < NW; w++) mem[w] <= memInit(w);
      memReady <= 1'b1;
    end else if (ram_wren) begin
      for (int b = 0; b < BE; b++)
        if (ram_byteena[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    rdPipe[0] <= ram_rden ? mem[ram_addr] : {8{$urandom}};
    for (int k = 1; k < RAM_LAT; k++) rdPipe[k] <= rdPipe[k-1];
  end
  assign ram_rdata = rdPipe[RAM_LAT-1];

  // Monitor: gathers strobe statistics per access and checks against the scoreboard at DONE
  int cyc = 0, riseCyc = 0, nRd = 0, nWr = 0, bePop = 0, firstAddr = -1;
  bit prevBusy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prevBusy = 1'b0;
      sbq.delete();
    end else begin
      item_t it;
      cyc++;
      if (busy && !prevBusy) begin
        riseCyc = cyc; nRd = 0; nWr = 0; bePop = 0; firstAddr = -1;
      end
      if (ram_rden || ram_wren) begin
        strobeCnt++;
        if (firstAddr < 0) firstAddr = int'(ram_addr);
        nRd += int'(ram_rden);
        nWr += int'(ram_wren);
        bePop += $countones(ram_byteena);
        if (!busy) strayCnt++;
        if (ram_rden && ram_wren) bothCnt++;
      end
      if (prevBusy && !busy) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got completion expected none at cycle %0d", cyc);
        end else begin
          it = sbq.pop_front();
          chk("latency", BW'(cyc - riseCyc), BW'(it.lat + 1));
          chk("rden_beats", BW'(nRd), BW'(it.wr ? 0 : it.beats));
          chk("wren_beats", BW'(nWr), BW'(it.wr ? it.beats : 0));
          chk("byteena_pop", BW'(bePop), BW'(it.bePB * it.beats));
          chk("first_addr", BW'(firstAddr), BW'(it.firstWord));
          chk("scalar_rdata", BW'(scalar_rdata), BW'(it.expS));
          chk("vec_rdata", vec_rdata, it.expV);
          if (it.wr)
            for (int i = 0; i < it.nWords; i++)
              chk("ram_word", mem[it.words[i]], refMem[it.words[i]]);
        end
        doneCnt++;
      end
      prevBusy = busy;
    end
  end

  // Reference model: element-level address arithmetic straight from the access rules
  task automatic doOp(input bit rd, input bit wr, input bit vm, input logic [31:0] a,
                      input logic [ADDR_W-1:0] st, input logic [LANE_W-1:0] sd, input logic [BW-1:0] vd);
    item_t it;
    int e, word, lane, ei, w, l, d0, cnt;
    bit strided;
    e = int'(a % (32'd1 << EW));
    word = e / LANES;
    lane = e % LANES;
    strided = vm && (st != 1) && STRIDE_EN;
    it.wr = wr;
    it.firstWord = word;
    it.words = '0;
    if (!vm) begin
      it.beats = 1; it.bePB = LANE_W/8; it.nWords = 1; it.words[0] = ADDR_W'(word);
      if (wr) refMem[word][lane*LANE_W +: LANE_W] = sd;
      else    curS = 32'(refMem[word][lane*LANE_W +: LANE_W]);
      it.lat = wr ? 1 : RAM_LAT + 1;
    end else if (!strided) begin
      it.beats = 1; it.bePB = BE; it.nWords = 1; it.words[0] = ADDR_W'(word);
      if (wr) refMem[word] = vd;
      else    curV = refMem[word];
      it.lat = wr ? 1 : RAM_LAT + 1;
    end else begin
      it.beats = LANES; it.bePB = LANE_W/8; it.nWords = LANES;
      for (int i = 0; i < LANES; i++) begin
        ei = (e + i * int'(st)) % (1 << EW);
        w = ei / LANES; l = ei % LANES;
        it.words[i] = ADDR_W'(w);
        if (wr) refMem[w][l*LANE_W +: LANE_W] = vd[i*LANE_W +: LANE_W];
        else    curV[i*LANE_W +: LANE_W] = refMem[w][l*LANE_W +: LANE_W];
      end
      it.lat = wr ? LANES : LANES * (RAM_LAT + 1);
    end
    it.expS = curS;
    it.expV = curV;
    sbq.push_back(it);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; vec_mode = vm; addr = a; stride = st;
    scalar_wdata = sd; vec_wdata = vd;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    d0 = doneCnt; cnt = 0;
    while (doneCnt == d0 && cnt < 400) begin @(posedge clk); cnt++; end
    if (doneCnt == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no completion expected one within 400 cycles");
      sbq.delete();
    end
  endtask

  initial begin
    int s0;
    logic [BW-1:0] vd;
    for (int w = 0; w < NW; w++) refMem[w] = memInit(w);
    curS = '0; curV = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", BW'(busy), '0);
    chk("rst_rden", BW'(ram_rden), '0);
    chk("rst_wren", BW'(ram_wren), '0);
    chk("rst_addr", BW'(ram_addr), '0);
    chk("rst_byteena", BW'(ram_byteena), '0);
    chk("rst_wdata", ram_wdata, '0);
    chk("rst_scalar", BW'(scalar_rdata), '0);
    chk("rst_vec", vec_rdata, '0);

    doOp(1, 0, 1, 32'h20, 14'd1, '0, '0);
    doOp(0, 1, 0, 32'h23, 14'd0, 16'hBEEF, '0);
    chk("lane3_beef", BW'(mem[2][3*LANE_W +: LANE_W]), BW'(16'hBEEF));
    if (STRIDE_EN) doOp(1, 0, 1, 32'h0, 14'd17, '0, '0);
    doOp(1, 1, 0, 32'h45, 14'd0, 16'h1234, '0);
    doOp(1, 1, 1, 32'h80, 14'd1, '0, {8{$urandom}});

    for (int n = 0; n < 40; n++) begin
      int k;
      bit rd, wr, vm;
      logic [ADDR_W-1:0] st;
      k = $urandom_range(0, 5);
      vm = (k >= 2);
      rd = (k == 0 || k == 2 || k >= 4);
      wr = (k == 1 || k == 3 || k == 4);
      if (k == 4) vm = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? ADDR_W'(1) : ADDR_W'($urandom_range(0, NW-1));
      vd = {8{$urandom}};
      doOp(rd, wr, vm, $urandom, st, 16'($urandom), vd);
    end

    // Abort mid-operation: strided write at beat 5 when enabled, else a vector read in flight
    @(posedge clk); #1;
    vd = {8{$urandom}};
    mem_write = STRIDE_EN; mem_read = !STRIDE_EN; vec_mode = 1; addr = 32'h100;
    stride = STRIDE_EN ? 14'd17 : 14'd1; vec_wdata = vd;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    if (STRIDE_EN) begin
      for (int i = 0; i < 6; i++) refMem[16 + i][i*LANE_W +: LANE_W] = vd[i*LANE_W +: LANE_W];
      repeat (5) @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    curS = '0; curV = '0;
    chk("abort_busy", BW'(busy), '0);
    chk("abort_rden", BW'(ram_rden), '0);
    chk("abort_wren", BW'(ram_wren), '0);
    s0 = strobeCnt;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_strobe", BW'(strobeCnt - s0), '0);
    chk("abort_vec", vec_rdata, '0);
    for (int i = 0; i < 16; i++) chk("abort_word", mem[16 + i], refMem[16 + i]);

    doOp(1, 0, 0, (32'd1 << EW) + 32'h11, 14'd0, '0, '0);
    chk("wrap_scalar", BW'(scalar_rdata), BW'(32'(memInit(1)[LANE_W +: LANE_W])));
    chk("no_stray_strobe", BW'(strayCnt), '0);
    chk("never_both", BW'(bothCnt), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
